// File: rtl/cpu_pkg.sv
// cpu_pkg: types and constants shared by the 8-bit CPU memory-port logic.
//   state_e        - memory sequencer FSM states
//   REQ_CPU/LDR    - requester indices (CPU core, program loader)
//   DEF_*_W        - default bus widths
//   onehot2()      - 1-bit requester index to 2-bit one-hot vector
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2
  } state_e;

  localparam int REQ_CPU = 0;
  localparam int REQ_LDR = 1;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;

  function automatic logic [1:0] onehot2(input logic idx);
    logic [1:0] v;
    v      = 2'b00;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker with owner lock override.
//   req_i[1:0]   - request per requester
//   lock_i[1:0]  - lock request per requester
//   owner_i      - current bus owner
//   last_i       - requester granted most recently
//   lock_ok_i    - lock override permitted this cycle
//   winner_o     - chosen requester index (meaningful when valid_o)
//   valid_o      - at least one requester is asking
module rr_pick2
  import cpu_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic [1:0] lock_i,
  input  logic       owner_i,
  input  logic       last_i,
  input  logic       lock_ok_i,
  output logic       winner_o,
  output logic       valid_o
);

  always_comb begin
    winner_o = 1'(REQ_CPU);
    valid_o  = |req_i;
    // A lock only counts while its owner is still requesting.
    if (lock_ok_i && req_i[owner_i] && lock_i[owner_i]) begin
      winner_o = owner_i;
    end else if (req_i == 2'b11) begin
      winner_o = ~last_i;
    end else begin
      winner_o = req_i[REQ_LDR];
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: serialises CPU (requester 0) and loader (requester 1)
// single-byte transactions onto one synchronous-read memory port.
//   clk, reset             - clock; asynchronous active-low reset
//   req, lock, we          - per-requester request / keep-ownership / write
//   addr_in, wdata         - per-requester address and write data (packed)
//   gnt, done              - one-hot grant (ACCESS) and completion (COMPLETE)
//   rdata                  - per-requester read data, held between completions
//   address, to_memory     - memory bus, held outside ACCESS
//   from_memory            - memory read data, one cycle after address
//   write                  - memory write strobe, ACCESS only
module mem_bus_arbiter
  import cpu_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req,
  input  logic [1:0]          lock,
  input  logic [1:0]          we,
  input  logic [2*ADDR_W-1:0] addr_in,
  input  logic [2*DATA_W-1:0] wdata,
  output logic [1:0]          gnt,
  output logic [1:0]          done,
  output logic [2*DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W-1:0]   to_memory,
  input  logic [DATA_W-1:0]   from_memory,
  output logic                write
);

  // Counter only needs to reach MAX_BURST-1, where it saturates.
  localparam int              CNT_W   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [DATA_W-1:0]   to_memory_q, to_memory_d;
  logic [2*DATA_W-1:0] rdata_q, rdata_d;

  logic lock_ok;
  logic win;
  logic win_valid;
  logic grant;

  assign lock_ok = (state_q == COMPLETE) && (cnt_q < CNT_MAX);

  rr_pick2 u_pick (
    .req_i     (req),
    .lock_i    (lock),
    .owner_i   (owner_q),
    .last_i    (last_q),
    .lock_ok_i (lock_ok),
    .winner_o  (win),
    .valid_o   (win_valid)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    address_d   = address_q;
    to_memory_d = to_memory_q;
    rdata_d     = rdata_q;
    grant       = 1'b0;

    case (state_q)
      IDLE: begin
        grant = win_valid;
      end
      ACCESS: begin
        state_d = COMPLETE;
      end
      COMPLETE: begin
        // Read data is captured for writes too; the requester just ignores it.
        if (owner_q) rdata_d[DATA_W +: DATA_W] = from_memory;
        else         rdata_d[0 +: DATA_W]      = from_memory;
        grant = win_valid;
        if (!win_valid) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (grant) begin
      state_d     = ACCESS;
      owner_d     = win;
      last_d      = win;
      we_d        = win ? we[1] : we[0];
      address_d   = win ? addr_in[ADDR_W +: ADDR_W] : addr_in[0 +: ADDR_W];
      to_memory_d = win ? wdata[DATA_W +: DATA_W]   : wdata[0 +: DATA_W];
      if (state_q == COMPLETE && win == owner_q) begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      end else begin
        cnt_d = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;   // CPU wins the first tie
      cnt_q       <= '0;
      we_q        <= 1'b0;
      address_q   <= '0;
      to_memory_q <= '0;
      // NOTE: the read-data holding registers are reset because their value
      // is architecturally visible on rdata straight out of reset.
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      address_q   <= address_d;
      to_memory_q <= to_memory_d;
      rdata_q     <= rdata_d;
    end
  end

  // Outputs decode registered state only, so an asynchronous reset clears
  // gnt/write immediately.
  assign gnt       = (state_q == ACCESS)   ? onehot2(owner_q) : 2'b00;
  assign done      = (state_q == COMPLETE) ? onehot2(owner_q) : 2'b00;
  assign write     = (state_q == ACCESS) && we_q;
  assign address   = address_q;
  assign to_memory = to_memory_q;
  // rdata_d already equals the held value with the owner's lane replaced by
  // from_memory during COMPLETE, which is exactly the visible rdata.
  assign rdata     = rdata_d;

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-requester arbiter and sequencer for the 8-bit CPU's single memory port. Requester 0 is the CPU core and requester 1 is the program loader (UART-fed DMA). Each requester issues single-byte read/write transactions with a req/gnt/done handshake. The block serialises them onto the `address` / `to_memory` / `from_memory` / `write` bus, using round-robin arbitration and bounded lock bursts.

## Interface
Parameters:
- `DATA_W`, 8: data bus width.
- `ADDR_W`, 8: address bus width.
- `MAX_BURST`, 4: maximum consecutive locked grants to one owner (≥1).

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  2  per-requester transaction request (level).
- `lock`  in  2  per-requester request to keep ownership for the next transaction.
- `we`  in  2  per-requester write enable (1 = write, 0 = read).
- `addr_in`  in  2*ADDR_W  requester n address at [ADDR_W*n +: ADDR_W].
- `wdata`  in  2*DATA_W  requester n write data at [DATA_W*n +: DATA_W].
- `gnt`  out  2  one-hot grant pulse.
- `done`  out  2  one-hot completion pulse.
- `rdata`  out  2*DATA_W  per-requester read data.
- `address`  out  ADDR_W  memory address.
- `to_memory`  out  DATA_W  memory write data.
- `from_memory`  in  DATA_W  memory read data; synchronous read, valid one cycle after `address`.
- `write`  out  1  memory write strobe.

## Operation
FSM states:
- IDLE: no transaction.
  - Arbitrates every cycle.
  - Any `req` → ACCESS.
- ACCESS:
  - Drives the winner's latched `addr`/`we`/`wdata` onto the memory bus.
  - `gnt[owner]`=1; `write`=`we` of the owner.
  - → COMPLETE unconditionally.
- COMPLETE:
  - `done[owner]`=1; `rdata[owner]` = `from_memory` (reads and writes alike).
  - Arbitrates again.
  - Any `req` → ACCESS (back-to-back, no IDLE bubble); else → IDLE.

Arbitration (IDLE and COMPLETE):
- Single requester: it wins.
- Both requesting: the one not granted last wins (round-robin via `last` pointer).
- Lock override: in COMPLETE, if the current owner has `req` and `lock` high and `burst_cnt < MAX_BURST-1`, the owner wins regardless of round robin.

Burst counter (`burst_cnt`):
- Increments when the same owner is re-granted.
- Clears on ownership change or entry to IDLE.
- When `MAX_BURST`=1, lock has no effect.

Latching and handshake:
- Winner's `addr`/`we`/`wdata` are latched at the edge entering ACCESS.
- Requester must hold `req`/`addr`/`we`/`wdata` stable until it sees `gnt`.
- Requester drops `req` at the edge ending its `gnt` cycle unless it wants another transaction.
- `req` high in COMPLETE is always treated as a new transaction.

Hold behaviour:
- `rdata[n]` holds its last captured value until requester n's next COMPLETE.
- `address` and `to_memory` hold their last values outside ACCESS.
- `write`=0 outside ACCESS.

## Timing
- Request seen at the edge ending cycle N (IDLE): `gnt` and memory bus in cycle N+1; `done` and `rdata` in cycle N+2.
- Memory captures writes at the edge ending ACCESS.
- Peak throughput: one transaction per 2 cycles, sustained by COMPLETE→ACCESS chaining.
- `gnt`, `done` and `write` are each exactly one cycle wide, one-hot, never overlapping for different requesters.
- Reset values:
  - `gnt`=0, `done`=0, `rdata`=0, `address`=0, `to_memory`=0, `write`=0.
  - state=IDLE, `burst_cnt`=0.
  - `last`=1, so requester 0 (CPU) wins the first tie.
- Reset mid-transaction (asynchronous, active-low):
  - All outputs go to reset values immediately; an in-flight `write` deasserts at once.
  - The transaction is dropped; no `done` is issued.
  - After release, pending requests are re-arbitrated from IDLE.
- Simultaneous `req` deassert and `lock` assert: `lock` without `req` is ignored.

## Structure
- Shared package `cpu_pkg`:
  - FSM state enum {IDLE, ACCESS, COMPLETE}.
  - Requester index constants `REQ_CPU`=0, `REQ_LDR`=1.
  - Default widths (8/8).
- Natural sub-module: `rr_pick2`, combinational. Inputs: `req`, `lock`, `owner`, `last`, lock-allowed flag. Output: winner index plus valid. Keeps FSM and latch logic separate.

## Test plan
1. CPU read, mem[0x10]=0xA5, `req[0]`/`addr` 0x10 in IDLE at cycle 0 → cycle 1: `gnt[0]`=1, `address`=0x10, `write`=0. Cycle 2: `done[0]`=1, `rdata[7:0]`=0xA5.
2. Loader write 0x3C to 0x20 → `write`=1 and `to_memory`=0x3C only in the ACCESS cycle. Following CPU read of 0x20 → `rdata[7:0]`=0x3C.
3. Both requesters pulse `req` in the same cycle after reset → CPU granted first. Loader `gnt[1]` in the cycle right after CPU COMPLETE (cycle 3). With continuous requests, grants alternate 0,1,0,1.
4. `MAX_BURST`=4, loader holds `req`+`lock`, CPU requesting throughout → exactly 4 consecutive loader grants, then `gnt[0]`, then the loader again.
5. Reset asserted during a write ACCESS (`write`=1) → `write` and `gnt` drop immediately, no `done`. After release with both requests held, the CPU is granted first.
6. No requests for 10 cycles after a transaction → state IDLE, `write`=0, `address`/`to_memory`/`rdata` hold their last values, no `gnt`/`done` pulses.
